// File: rtl/framebuffer_swapchain_if.sv
// Bus between the rasteriser / scan-out pair and the framebuffer swap chain.
// Also carries the swap-chain bookkeeping (state, buffer indices) for observation.
interface framebuffer_swapchain_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
);
  // swap_req/swap_ack: the GPU raises swap_req as a level and holds it until it
  // sees the one-cycle swap_ack pulse; a frame is accepted only on the clock edge
  // that sets swap_ack, and wr_ready low means pixel writes on wea are discarded.
  logic                  vsync;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  wr_ready;
  logic                  swap_req;
  logic                  swap_ack;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  flip;
  logic [1:0]            disp_idx;
  logic [1:0]            draw_idx;
  logic [1:0]            pend_idx;
  logic                  pend_valid;
  logic [1:0]            state;

  modport master (
    output vsync, wea, addra, dina, swap_req, addrb,
    input  wr_ready, swap_ack, doutb, flip, disp_idx,
    input  draw_idx, pend_idx, pend_valid, state
  );

  modport slave (
    input  vsync, wea, addra, dina, swap_req, addrb,
    output wr_ready, swap_ack, doutb, flip, disp_idx,
    output draw_idx, pend_idx, pend_valid, state
  );
endinterface

// File: rtl/framebuffer_swapchain.sv
// Double/triple-buffered framebuffer: GPU draws into one buffer, submits it with
// swap_req/swap_ack, and scan-out flips to the newest submitted frame on vsync fall.
module framebuffer_swapchain #(
  parameter int                    ADDR_WIDTH    = 17,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    FB_DEPTH      = 76800,
  parameter int                    NUM_BUFS      = 3,
  parameter int                    CLEAR_ON_SWAP = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input logic                    clk,
  input logic                    rst,
  framebuffer_swapchain_if.slave bus
);

  if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_num_bufs
    $error("framebuffer_swapchain: NUM_BUFS must be 2 or 3");
  end
  if (FB_DEPTH < 1 || FB_DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $error("framebuffer_swapchain: FB_DEPTH out of range for ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    DRAW      = 2'd1,
    WAIT_FLIP = 2'd2
  } state_t;

  localparam state_t                 AFTER_SWAP = (CLEAR_ON_SWAP != 0) ? CLEAR : DRAW;
  localparam int                     IDX_W      = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(FB_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]    DEPTH_EXT  = (ADDR_WIDTH + 1)'(FB_DEPTH);

  state_t                state, state_n;
  logic [1:0]            disp_idx, disp_n;
  logic [1:0]            draw_idx, draw_n;
  logic [1:0]            pend_idx, pend_n;
  logic                  pend_valid, pend_valid_n;
  logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_n;
  logic                  swap_ack, swap_ack_n;
  logic                  flip, flip_n;
  logic                  flip_take;
  logic                  accept;

  // Vsync: two-flop synchroniser plus one history flop for falling-edge detect.
  logic vs_s1, vs_s2, vs_s3;
  logic vs_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_s1 <= 1'b1;
      vs_s2 <= 1'b1;
      vs_s3 <= 1'b1;
    end else begin
      vs_s1 <= bus.vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  assign vs_edge = vs_s3 & ~vs_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= AFTER_SWAP;
      disp_idx   <= 2'd0;
      draw_idx   <= 2'd1;
      pend_idx   <= 2'd0;
      pend_valid <= 1'b0;
      clr_addr   <= '0;
      swap_ack   <= 1'b0;
      flip       <= 1'b0;
    end else begin
      state      <= state_n;
      disp_idx   <= disp_n;
      draw_idx   <= draw_n;
      pend_idx   <= pend_n;
      pend_valid <= pend_valid_n;
      clr_addr   <= clr_addr_n;
      swap_ack   <= swap_ack_n;
      flip       <= flip_n;
    end
  end

  // The flip is resolved first against pre-cycle state; a swap accepted on the
  // same edge then works on the post-flip view (disp_n, flip-cleared pend_valid).
  always_comb begin
    state_n      = state;
    disp_n       = disp_idx;
    draw_n       = draw_idx;
    pend_n       = pend_idx;
    pend_valid_n = pend_valid;
    clr_addr_n   = clr_addr;
    swap_ack_n   = 1'b0;
    flip_n       = 1'b0;
    flip_take    = vs_edge && pend_valid;
    // Blocking re-acceptance in the ack cycle keeps a slow-to-drop req from double-swapping.
    accept       = (state == DRAW) && bus.swap_req && !swap_ack;

    if (flip_take) begin
      disp_n       = pend_idx;
      pend_valid_n = 1'b0;
      flip_n       = 1'b1;
    end

    case (state)
      CLEAR: begin
        if (clr_addr == LAST_ADDR) begin
          clr_addr_n = '0;
          state_n    = DRAW;
        end else begin
          clr_addr_n = clr_addr + 1'b1;
        end
      end
      DRAW: begin
        if (accept) begin
          swap_ack_n   = 1'b1;
          pend_n       = draw_idx;
          pend_valid_n = 1'b1;
          if (NUM_BUFS == 2) begin
            state_n = WAIT_FLIP;
          end else begin
            // Latest frame wins: recycle the unshown pending buffer, else take the free one.
            draw_n  = (pend_valid && !flip_take) ? pend_idx : (2'd3 - disp_n - draw_idx);
            state_n = AFTER_SWAP;
          end
        end
      end
      WAIT_FLIP: begin
        if (flip_take) begin
          draw_n  = disp_idx;
          state_n = AFTER_SWAP;
        end
      end
      default: state_n = AFTER_SWAP;
    endcase
  end

  logic                  wr_ready;
  logic                  draw_we;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  assign wr_ready = (state == DRAW) && !rst;
  assign draw_we  = wr_ready && bus.wea && ({1'b0, bus.addra} < DEPTH_EXT);
  assign wr_en    = !rst && ((state == CLEAR) || draw_we);
  assign wr_addr  = (state == CLEAR) ? clr_addr : bus.addra;
  assign wr_data  = (state == CLEAR) ? CLEAR_VALUE : bus.dina;

  logic [DATA_WIDTH-1:0] rd_all [4];
  logic [1:0]            disp_q;

  for (genvar b = 0; b < 4; b++) begin : g_buf
    if (b < NUM_BUFS) begin : g_ram
      logic [DATA_WIDTH-1:0] mem [FB_DEPTH];
      logic [DATA_WIDTH-1:0] rd_q;

      always_ff @(posedge clk) begin
        if (wr_en && (draw_idx == 2'(b))) begin
          mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
        rd_q <= mem[bus.addrb[IDX_W-1:0]];
      end

      assign rd_all[b] = rd_q;
    end else begin : g_none
      assign rd_all[b] = '0;
    end
  end

  // Read mux follows the buffer that was displayed when the read was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= 2'd0;
    end else begin
      disp_q <= disp_idx;
    end
  end

  assign bus.doutb      = rd_all[disp_q];
  assign bus.wr_ready   = wr_ready;
  assign bus.swap_ack   = swap_ack;
  assign bus.flip       = flip;
  assign bus.disp_idx   = disp_idx;
  assign bus.draw_idx   = draw_idx;
  assign bus.pend_idx   = pend_idx;
  assign bus.pend_valid = pend_valid;
  assign bus.state      = state;

endmodule

// File: tb/tb_framebuffer_swapchain.sv
// Directed bench for framebuffer_swapchain: a 3-buffer and a 2-buffer instance,
// 16-pixel buffers, non-zero clear colour so the clear engine is observable.
module tb_framebuffer_swapchain;
  localparam int         AW      = 5;
  localparam int         DW      = 8;
  localparam int         DEPTH   = 16;
  localparam logic [7:0] CV      = 8'hC3;
  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  framebuffer_swapchain_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();
  framebuffer_swapchain_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

  framebuffer_swapchain #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FB_DEPTH(DEPTH), .NUM_BUFS(3),
    .CLEAR_ON_SWAP(1), .CLEAR_VALUE(CV)
  ) dut3 (.clk(clk), .rst(rst), .bus(if3));

  framebuffer_swapchain #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FB_DEPTH(DEPTH), .NUM_BUFS(2),
    .CLEAR_ON_SWAP(1), .CLEAR_VALUE(CV)
  ) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // ---- clock / reset ----
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if3.vsync = 1'b1; if3.wea = 1'b0; if3.addra = '0; if3.dina = '0; if3.swap_req = 1'b0; if3.addrb = '0;
    if2.vsync = 1'b1; if2.wea = 1'b0; if2.addra = '0; if2.dina = '0; if2.swap_req = 1'b0; if2.addrb = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write3(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if3.wea = 1'b1; if3.addra = a; if3.dina = d;
    tick();
    if3.wea = 1'b0;
  endtask

  task automatic write2(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if2.wea = 1'b1; if2.addra = a; if2.dina = d;
    tick();
    if2.wea = 1'b0;
  endtask

  task automatic read3(input logic [AW-1:0] a, output logic [DW-1:0] d);
    if3.addrb = a;
    tick();
    d = if3.doutb;
  endtask

  task automatic read2(input logic [AW-1:0] a, output logic [DW-1:0] d);
    if2.addrb = a;
    tick();
    d = if2.doutb;
  endtask

  task automatic wait_ready3(input string name);
    int n = 0;
    while (if3.wr_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (if3.wr_ready !== 1'b1) begin errors++; $display("FAIL %s: wr_ready got %b want 1 within 40 cycles", name, if3.wr_ready); end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (if3.disp_idx !== 2'd0) begin errors++; $display("FAIL rst_disp: got %0d want 0", if3.disp_idx); end
    checks++; if (if3.draw_idx !== 2'd1) begin errors++; $display("FAIL rst_draw: got %0d want 1", if3.draw_idx); end
    checks++; if (if3.pend_valid !== 1'b0) begin errors++; $display("FAIL rst_pend_valid: got %b want 0", if3.pend_valid); end
    checks++; if ({if3.wr_ready, if3.swap_ack, if3.flip} !== 3'b000) begin errors++; $display("FAIL rst_outputs: got %b want 000", {if3.wr_ready, if3.swap_ack, if3.flip}); end
    checks++; if (if3.state !== S_CLEAR) begin errors++; $display("FAIL rst_state: got %0d want %0d", if3.state, S_CLEAR); end
    checks++; if (if2.draw_idx !== 2'd1 || if2.disp_idx !== 2'd0) begin errors++; $display("FAIL rst_idx2: got draw %0d disp %0d want 1 0", if2.draw_idx, if2.disp_idx); end
    rst = 1'b0;
    repeat (15) tick();
    checks++; if (if3.wr_ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b want 0 after 15 clear cycles", if3.wr_ready); end
    tick();
    checks++; if (if3.wr_ready !== 1'b1 || if3.state !== S_DRAW) begin errors++; $display("FAIL ready_after_clear: got ready %b state %0d want 1 %0d", if3.wr_ready, if3.state, S_DRAW); end
    checks++; if (if2.wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clear2: got %b want 1", if2.wr_ready); end
  endtask

  task automatic test_first_frame();
    logic [DW-1:0] d;
    logic [DW-1:0] want;
    write3(5'd5, 8'hA5);
    write3(5'd20, 8'hEE);
    if3.swap_req = 1'b1;
    tick();
    checks++; if (if3.swap_ack !== 1'b1) begin errors++; $display("FAIL swap_ack: got %b want 1", if3.swap_ack); end
    checks++; if ({if3.pend_valid, if3.pend_idx, if3.draw_idx} !== {1'b1, 2'd1, 2'd2}) begin errors++; $display("FAIL swap_idx: got pv %b pend %0d draw %0d want 1 1 2", if3.pend_valid, if3.pend_idx, if3.draw_idx); end
    checks++; if (if3.state !== S_CLEAR || if3.wr_ready !== 1'b0) begin errors++; $display("FAIL swap_clear: got state %0d ready %b want %0d 0", if3.state, if3.wr_ready, S_CLEAR); end
    if3.swap_req = 1'b0;
    tick();
    checks++; if (if3.swap_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %b want 0", if3.swap_ack); end
    if3.vsync = 1'b0;
    tick();
    tick();
    checks++; if (if3.flip !== 1'b0) begin errors++; $display("FAIL flip_early: got %b want 0", if3.flip); end
    tick();
    checks++; if (if3.flip !== 1'b1 || if3.disp_idx !== 2'd1 || if3.pend_valid !== 1'b0) begin errors++; $display("FAIL flip_first: got flip %b disp %0d pv %b want 1 1 0", if3.flip, if3.disp_idx, if3.pend_valid); end
    tick();
    checks++; if (if3.flip !== 1'b0) begin errors++; $display("FAIL flip_pulse: got %b want 0", if3.flip); end
    repeat (3) tick();
    checks++; if (if3.flip !== 1'b0) begin errors++; $display("FAIL flip_once: got %b want 0 with vsync held low", if3.flip); end
    if3.vsync = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      want = (a == 5) ? 8'hA5 : CV;
      read3(AW'(a), d);
      checks++; if (d !== want) begin errors++; $display("FAIL frame1_pix%0d: got %h want %h", a, d, want); end
    end
    wait_ready3("ready_after_swap1");
  endtask

  task automatic test_mailbox();
    logic [DW-1:0] d;
    write3(5'd3, 8'h11);
    if3.swap_req = 1'b1;
    tick();
    if3.swap_req = 1'b0;
    checks++; if ({if3.swap_ack, if3.pend_idx, if3.draw_idx} !== {1'b1, 2'd2, 2'd0}) begin errors++; $display("FAIL mbox_swap1: got ack %b pend %0d draw %0d want 1 2 0", if3.swap_ack, if3.pend_idx, if3.draw_idx); end
    wait_ready3("mbox_ready1");
    write3(5'd3, 8'h22);
    if3.swap_req = 1'b1;
    tick();
    if3.swap_req = 1'b0;
    checks++; if ({if3.swap_ack, if3.pend_valid, if3.pend_idx, if3.draw_idx} !== {1'b1, 1'b1, 2'd0, 2'd2}) begin errors++; $display("FAIL mbox_swap2: got ack %b pv %b pend %0d draw %0d want 1 1 0 2", if3.swap_ack, if3.pend_valid, if3.pend_idx, if3.draw_idx); end
    wait_ready3("mbox_ready2");
    if3.vsync = 1'b0;
    repeat (3) tick();
    checks++; if (if3.flip !== 1'b1 || if3.disp_idx !== 2'd0) begin errors++; $display("FAIL mbox_flip: got flip %b disp %0d want 1 0", if3.flip, if3.disp_idx); end
    if3.vsync = 1'b1;
    read3(5'd3, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL mbox_pix3: got %h want 22", d); end
    read3(5'd4, d);
    checks++; if (d !== CV) begin errors++; $display("FAIL mbox_pix4: got %h want %h", d, CV); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] d;
    repeat (3) tick();
    write3(5'd7, 8'h33);
    if3.swap_req = 1'b1;
    tick();
    if3.swap_req = 1'b0;
    checks++; if ({if3.pend_idx, if3.draw_idx} !== {2'd2, 2'd1}) begin errors++; $display("FAIL sim_setup: got pend %0d draw %0d want 2 1", if3.pend_idx, if3.draw_idx); end
    wait_ready3("sim_ready1");
    write3(5'd7, 8'h44);
    if3.vsync = 1'b0;
    tick();
    tick();
    if3.swap_req = 1'b1;
    tick();
    if3.swap_req = 1'b0;
    checks++; if ({if3.flip, if3.swap_ack} !== 2'b11) begin errors++; $display("FAIL sim_pulses: got flip %b ack %b want 1 1", if3.flip, if3.swap_ack); end
    checks++; if ({if3.disp_idx, if3.pend_idx, if3.draw_idx, if3.pend_valid} !== {2'd2, 2'd1, 2'd0, 1'b1}) begin errors++; $display("FAIL sim_idx: got disp %0d pend %0d draw %0d pv %b want 2 1 0 1", if3.disp_idx, if3.pend_idx, if3.draw_idx, if3.pend_valid); end
    checks++; if (if3.draw_idx === if3.disp_idx || if3.pend_idx === if3.disp_idx || if3.pend_idx === if3.draw_idx) begin errors++; $display("FAIL sim_invariant: got disp %0d draw %0d pend %0d want all distinct", if3.disp_idx, if3.draw_idx, if3.pend_idx); end
    if3.vsync = 1'b1;
    read3(5'd7, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL sim_older_frame: got %h want 33", d); end
    wait_ready3("sim_ready2");
    if3.vsync = 1'b0;
    repeat (3) tick();
    checks++; if (if3.flip !== 1'b1 || if3.disp_idx !== 2'd1) begin errors++; $display("FAIL sim_flip2: got flip %b disp %0d want 1 1", if3.flip, if3.disp_idx); end
    if3.vsync = 1'b1;
    read3(5'd7, d);
    checks++; if (d !== 8'h44) begin errors++; $display("FAIL sim_newer_frame: got %h want 44", d); end
  endtask

  task automatic test_no_pend_vsync();
    int flips = 0;
    checks++; if (if3.pend_valid !== 1'b0) begin errors++; $display("FAIL nopend_pv: got %b want 0", if3.pend_valid); end
    for (int p = 0; p < 3; p++) begin
      if3.vsync = 1'b0;
      repeat (5) begin tick(); if (if3.flip === 1'b1) flips++; end
      if3.vsync = 1'b1;
      repeat (5) begin tick(); if (if3.flip === 1'b1) flips++; end
    end
    checks++; if (flips !== 0) begin errors++; $display("FAIL nopend_flip: got %0d flips want 0", flips); end
    checks++; if (if3.disp_idx !== 2'd1) begin errors++; $display("FAIL nopend_disp: got %0d want 1", if3.disp_idx); end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    repeat (7) tick();
    checks++; if (if3.state !== S_CLEAR) begin errors++; $display("FAIL midclr_state: got %0d want %0d", if3.state, S_CLEAR); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (15) tick();
    checks++; if (if3.wr_ready !== 1'b0) begin errors++; $display("FAIL midclr_early: got %b want 0 after 15 cycles", if3.wr_ready); end
    tick();
    checks++; if (if3.wr_ready !== 1'b1) begin errors++; $display("FAIL midclr_ready: got %b want 1 after 16 cycles", if3.wr_ready); end
  endtask

  task automatic test_two_buf();
    logic [DW-1:0] d;
    write2(5'd9, 8'h55);
    if2.swap_req = 1'b1;
    tick();
    if2.swap_req = 1'b0;
    checks++; if ({if2.swap_ack, if2.wr_ready, if2.state} !== {1'b1, 1'b0, S_WAIT}) begin errors++; $display("FAIL two_swap: got ack %b ready %b state %0d want 1 0 %0d", if2.swap_ack, if2.wr_ready, if2.state, S_WAIT); end
    checks++; if ({if2.pend_valid, if2.pend_idx} !== {1'b1, 2'd1}) begin errors++; $display("FAIL two_pend: got pv %b pend %0d want 1 1", if2.pend_valid, if2.pend_idx); end
    if2.wea = 1'b1; if2.addra = 5'd9; if2.dina = 8'hFF;
    tick();
    if2.addra = 5'd2;
    tick();
    if2.vsync = 1'b0;
    tick();
    tick();
    checks++; if ({if2.flip, if2.wr_ready} !== 2'b00) begin errors++; $display("FAIL two_wait: got flip %b ready %b want 0 0", if2.flip, if2.wr_ready); end
    tick();
    if2.wea = 1'b0;
    checks++; if ({if2.flip, if2.disp_idx, if2.draw_idx, if2.state} !== {1'b1, 2'd1, 2'd0, S_CLEAR}) begin errors++; $display("FAIL two_flip: got flip %b disp %0d draw %0d state %0d want 1 1 0 %0d", if2.flip, if2.disp_idx, if2.draw_idx, if2.state, S_CLEAR); end
    if2.vsync = 1'b1;
    repeat (15) tick();
    checks++; if (if2.wr_ready !== 1'b0) begin errors++; $display("FAIL two_clear_early: got %b want 0", if2.wr_ready); end
    tick();
    checks++; if (if2.wr_ready !== 1'b1) begin errors++; $display("FAIL two_clear_done: got %b want 1", if2.wr_ready); end
    read2(5'd9, d);
    checks++; if (d !== 8'h55) begin errors++; $display("FAIL two_pix9: got %h want 55", d); end
    read2(5'd2, d);
    checks++; if (d !== CV) begin errors++; $display("FAIL two_pix2: got %h want %h", d, CV); end
  endtask

  // ---- sequence and report ----
  initial begin
    idle_inputs();
    test_reset();
    test_first_frame();
    test_mailbox();
    test_simultaneous();
    test_no_pend_vsync();
    test_reset_mid_clear();
    test_two_buf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
